xvk_fifo_burst_drain: RTL and testbench

XVK_FIFO_BURST_DRAIN -- requirements
Module: xvk_fifo_burst_drain

---
 rtl/xvk_fifo_burst_drain.sv | 100 ++++++++++
 tb/tb_xvk_fifo_burst_drain.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xvk_fifo_burst_drain.sv
// Drains a first-word-fall-through FIFO into bursts of BURST_LEN beats through a
// hold stage and a registered output stage; partial bursts close on flush or idle timeout.
module xvk_fifo_burst_drain #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
);

    localparam int POS_W  = $clog2(BURST_LEN);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [POS_W-1:0]  POS_END  = POS_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic              h_valid;
    logic [WIDTH-1:0]  h_data;
    logic [POS_W-1:0]  pos;
    logic [IDLE_W-1:0] idle_cnt;

    logic o_free;
    logic pos_end;
    logic close;
    logic h_to_o;
    logic load_last;
    logic idle_tick;

    // The held word only moves on while the FIFO still has data behind it, unless the
    // burst is already full or is being closed; otherwise it waits so m_last can be set.
    always_comb begin
        o_free     = !m_valid || m_ready;
        pos_end    = (pos == POS_END);
        close      = flush || (idle_cnt >= IDLE_MAX);
        h_to_o     = h_valid && o_free && (!fifo_empty || pos_end || close);
        load_last  = pos_end || (fifo_empty && close);
        idle_tick  = h_valid && fifo_empty && !h_to_o;
        fifo_rd_en = !rst && !fifo_empty && (!h_valid || h_to_o);
    end

    assign busy = h_valid || m_valid;

    // Stage H: head word captured on the edge that pops it
    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid <= 1'b0;
            h_data  <= '0;
        end else if (fifo_rd_en) begin
            h_valid <= 1'b1;
            h_data  <= fifo_dout;
        end else if (h_to_o) begin
            h_valid <= 1'b0;
        end
    end

    // Stage O: registered beat, frozen while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (h_to_o) begin
            m_valid <= 1'b1;
            m_data  <= h_data;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Burst position and idle timer
    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= '0;
            idle_cnt <= '0;
        end else begin
            if (h_to_o) begin
                pos <= load_last ? '0 : pos + 1'b1;
            end
            if (idle_tick) begin
                if (idle_cnt < IDLE_MAX) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_xvk_fifo_burst_drain.sv
// Bench for xvk_fifo_burst_drain: queue-based FIFO model, table-driven streaming check,
// hand-written corner sequences and a randomized run against an ordering/burst scoreboard.
module tb_xvk_fifo_burst_drain;

    localparam int W  = 16;
    localparam int BL = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [W-1:0] fifo_dout;
    logic         fifo_rd_en;
    logic         flush;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;

    xvk_fifo_burst_drain #(.WIDTH(W), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ready;
        logic         flsh;
        logic         rd;
        logic         valid;
        logic [W-1:0] data;
        logic         last;
        logic         bsy;
    } vec_t;

    vec_t         tbl [11];
    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];
    logic [W-1:0] rx_data[$];
    logic         rx_last[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int bcnt  = 0;
    int watch_cyc = -100;
    int vcyc;
    logic [W-1:0] watch_word = 16'h00A3;
    logic found;

    logic         obs_valid, obs_last, obs_rd, obs_busy;
    logic [W-1:0] obs_data;
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_data;
    logic         stall_last;
    logic         rst_s, rdy_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh();
    endtask

    // One clock cycle: observe, score, take the edge, pop the model FIFO.
    task automatic step();
        #1;
        obs_valid = m_valid;
        obs_data  = m_data;
        obs_last  = m_last;
        obs_rd    = fifo_rd_en;
        obs_busy  = busy;
        rst_s     = rst;
        rdy_s     = m_ready;
        if (stall_prev && !rst_s) begin
            chk("stall_valid_hold", obs_valid, 1);
            chk("stall_data_hold", obs_data, stall_data);
            chk("stall_last_hold", obs_last, stall_last);
        end
        if (obs_rd) chk("rd_en_while_empty", fifo_empty, 0);
        if (obs_rd && fifo_q.size() > 0 && fifo_q[0] == watch_word) watch_cyc = cyc;
        if (rst_s) bcnt = 0;
        if (!rst_s && obs_valid && rdy_s) begin
            chk("beat_pending", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("beat_data_order", obs_data, exp_q.pop_front());
            rx_data.push_back(obs_data);
            rx_last.push_back(obs_last);
            bcnt++;
            if (bcnt == BL) chk("full_burst_last", obs_last, 1);
            if (obs_last) bcnt = 0;
        end
        stall_prev = !rst_s && obs_valid && !rdy_s;
        stall_data = obs_data;
        stall_last = obs_last;
        @(posedge clk);
        if (obs_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        cyc++;
        #1;
        refresh();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_rx(input string name, input int n, input logic [W-1:0] first,
                            input logic [7:0] lasts);
        chk({name, "_count"}, rx_data.size(), n);
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            chk({name, "_data"}, rx_data[i], first + W'(i));
            chk({name, "_last"}, rx_last[i], lasts[i]);
        end
        rx_data.delete();
        rx_last.delete();
    endtask

    function automatic vec_t mk(input logic rd, input logic v, input logic [W-1:0] d,
                                input logic l, input logic b);
        vec_t t;
        t.ready = 1'b1;
        t.flsh  = 1'b0;
        t.rd    = rd;
        t.valid = v;
        t.data  = d;
        t.last  = l;
        t.bsy   = b;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Preloaded 1..8 stream, cycle 0 = first cycle out of reset
        tbl[0]  = mk(1, 0, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 0, 16'h0000, 0, 1);
        tbl[2]  = mk(1, 1, 16'h0001, 0, 1);
        tbl[3]  = mk(1, 1, 16'h0002, 0, 1);
        tbl[4]  = mk(1, 1, 16'h0003, 0, 1);
        tbl[5]  = mk(1, 1, 16'h0004, 1, 1);
        tbl[6]  = mk(1, 1, 16'h0005, 0, 1);
        tbl[7]  = mk(1, 1, 16'h0006, 0, 1);
        tbl[8]  = mk(0, 1, 16'h0007, 0, 1);
        tbl[9]  = mk(0, 1, 16'h0008, 1, 1);
        tbl[10] = mk(0, 0, 16'h0000, 0, 0);

        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        refresh();
        for (int i = 1; i <= 8; i++) push(W'(i));
        run(2);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", fifo_rd_en, 0);

        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            m_ready = tbl[i].ready;
            flush   = tbl[i].flsh;
            step();
            chk("tbl_rd_en", obs_rd, tbl[i].rd);
            chk("tbl_valid", obs_valid, tbl[i].valid);
            chk("tbl_busy", obs_busy, tbl[i].bsy);
            if (tbl[i].valid) begin
                chk("tbl_data", obs_data, tbl[i].data);
                chk("tbl_last", obs_last, tbl[i].last);
            end
        end
        rx_data.delete();
        rx_last.delete();

        // Partial burst closed by the idle timeout
        push(16'h00A1); push(16'h00A2); push(16'h00A3);
        found = 1'b0;
        vcyc  = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (obs_valid && obs_data == 16'h00A3) begin
                found = 1'b1;
                vcyc  = cyc - 1;
            end
        end
        chk("a3_seen", found, 1);
        chk("a3_pop_to_valid", vcyc - watch_cyc, 10);
        chk("a3_last", obs_last, 1);
        check_rx("a_burst", 3, 16'h00A1, 8'b0000_0100);
        for (int i = 0; i < 4; i++) push(16'h00B1 + W'(i));
        run(16);
        check_rx("b_burst", 4, 16'h00B1, 8'b0000_1000);

        // Downstream stall
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(W'(i));
        run(2);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", obs_valid, 1);
            chk("stall_data", obs_data, 16'h0001);
            chk("stall_rd_en", obs_rd, 0);
        end
        m_ready = 1'b1;
        run(40);
        check_rx("stall_burst", 6, 16'h0001, 8'b0010_1000);

        // Flush closes the partial burst immediately
        push(16'h00D1); push(16'h00D2);
        run(3);
        flush = 1'b1;
        step();
        chk("flush_pre_valid", obs_valid, 0);
        flush = 1'b0;
        step();
        chk("flush_valid", obs_valid, 1);
        chk("flush_data", obs_data, 16'h00D2);
        chk("flush_last", obs_last, 1);
        chk("flush_idle_cnt", dut.idle_cnt, 0);
        run(3);
        check_rx("flush_burst", 2, 16'h00D1, 8'b0000_0010);

        // Flush with nothing held must leave no trace
        flush = 1'b1;
        run(2);
        flush = 1'b0;
        chk("idle_flush_busy", busy, 0);

        // Reset in mid-burst
        for (int i = 0; i < 6; i++) push(16'h00E1 + W'(i));
        run(4);
        check_rx("e_pre_reset", 2, 16'h00E1, 8'b0000_0000);
        rst = 1'b1;
        step();
        chk("midrst_rd_en", obs_rd, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_last", m_last, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        rx_data.delete();
        rx_last.delete();
        refresh();
        for (int i = 0; i < 4; i++) push(16'h00F1 + W'(i));
        run(12);
        check_rx("f_after_reset", 4, 16'h00F1, 8'b0000_1000);

        // Randomized traffic, backpressure and flushes
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 45) push(W'($urandom));
            m_ready = ($urandom_range(0, 99) < 70);
            flush   = ($urandom_range(0, 99) < 3);
            step();
        end
        m_ready = 1'b1;
        flush   = 1'b0;
        for (int k = 0; k < 400 && (exp_q.size() > 0 || m_valid); k++) step();
        chk("random_drained", exp_q.size(), 0);
        run(2);
        chk("random_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
